// File: rtl/score_display_pkg.sv
// Shared constants for the score display: segment codes (active-low {g,f,e,d,c,b,a})
// and the converter state encoding.
package score_display_pkg;

    localparam int SCORE_W    = 7;
    localparam int NUM_DIGITS = 4;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_DONE    = 2'd2
    } conv_state_e;

    function automatic logic [6:0] seg_encode(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'd0:    code = SEG_0;
            4'd1:    code = SEG_1;
            4'd2:    code = SEG_2;
            4'd3:    code = SEG_3;
            4'd4:    code = SEG_4;
            4'd5:    code = SEG_5;
            4'd6:    code = SEG_6;
            4'd7:    code = SEG_7;
            4'd8:    code = SEG_8;
            4'd9:    code = SEG_9;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/score_display_bin2bcd_seq.sv
// Serial double-dabble: one add-3/shift step per clock, SCORE_W steps per conversion.
// done_o is high during the single DONE cycle while bcd_o holds the finished digits.
module bin2bcd_seq
    import score_display_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [SCORE_W-1:0] bin_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [11:0]        bcd_o
);

    localparam int SR_W  = 12 + SCORE_W;
    localparam int CNT_W = $clog2(SCORE_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCORE_W - 1);

    conv_state_e       state_q;
    logic [SR_W-1:0]   sr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;

    function automatic logic [SR_W-1:0] dabble_step(input logic [SR_W-1:0] sr);
        logic [SR_W-1:0] adj;
        adj = sr;
        for (int n = 0; n < 3; n++) begin
            if (adj[SCORE_W + 4*n +: 4] >= 4'd5)
                adj[SCORE_W + 4*n +: 4] = adj[SCORE_W + 4*n +: 4] + 4'd3;
        end
        return {adj[SR_W-2:0], 1'b0};
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        sr_q    <= {12'd0, bin_i};
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_CONVERT;
                    end
                end
                ST_CONVERT: begin
                    sr_q  <= dabble_step(sr_q);
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST)
                        state_q <= ST_DONE;
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o = busy_q;
    assign done_o = (state_q == ST_DONE);
    assign bcd_o  = sr_q[SR_W-1:SCORE_W];

endmodule

// File: rtl/score_display.sv
// Best-score tracking, change-triggered BCD conversion and a multiplexed
// 4-digit common-anode scan with leading-zero blanking.
module score_display #(
    parameter int REFRESH_DIV = 100000,
    parameter int SCORE_W     = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SCORE_W-1:0] score,
    input  logic               show_best,
    output logic [6:0]         seg,
    output logic               dp,
    output logic [3:0]         an,
    output logic [SCORE_W-1:0] best_out,
    output logic               busy
);
    import score_display_pkg::*;

    localparam int RC_W  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(REFRESH_DIV - 1);

    logic [SCORE_W-1:0] score_q, best_q, last_q, sel_val;
    logic [11:0]        disp_bcd_q, conv_bcd;
    logic               conv_busy, conv_done, start;
    logic [RC_W-1:0]    rc_q;
    logic [IDX_W-1:0]   idx_q;
    logic [6:0]         seg_d, seg_q;
    logic [3:0]         an_d, an_q;
    logic               dp_d, dp_q;
    logic [3:0]         digit_nib;
    logic               digit_blank;

    assign sel_val = show_best ? best_q : score_q;
    // A change seen while the engine is busy waits until it is back in IDLE.
    assign start   = !conv_busy && (sel_val != last_q);

    bin2bcd_seq u_bin2bcd (
        .clk     (clk),
        .rst_n   (rst_n),
        .start_i (start),
        .bin_i   (sel_val),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

    always_comb begin
        digit_nib   = 4'd0;
        digit_blank = 1'b1;
        case (idx_q)
            2'd0: begin
                digit_nib   = disp_bcd_q[3:0];
                digit_blank = 1'b0;
            end
            2'd1: begin
                digit_nib   = disp_bcd_q[7:4];
                digit_blank = (disp_bcd_q[11:4] == 8'd0);
            end
            2'd2: begin
                digit_nib   = disp_bcd_q[11:8];
                digit_blank = (disp_bcd_q[11:8] == 4'd0);
            end
            default: digit_blank = 1'b1;
        endcase
        seg_d = digit_blank ? SEG_BLANK : seg_encode(digit_nib);
        an_d  = digit_blank ? 4'hF : ~(4'b0001 << idx_q);
        dp_d  = !((idx_q == 2'd0) && show_best);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q    <= '0;
            best_q     <= '0;
            last_q     <= '0;
            disp_bcd_q <= '0;
            rc_q       <= '0;
            idx_q      <= '0;
            seg_q      <= SEG_BLANK;
            an_q       <= 4'hF;
            dp_q       <= 1'b1;
        end else begin
            score_q <= score;
            if (score_q > best_q)
                best_q <= score_q;
            if (start)
                last_q <= sel_val;
            if (conv_done)
                disp_bcd_q <= conv_bcd;
            if (rc_q == RC_LAST) begin
                rc_q  <= '0;
                idx_q <= idx_q + 1'b1;
            end else begin
                rc_q <= rc_q + 1'b1;
            end
            seg_q <= seg_d;
            an_q  <= an_d;
            dp_q  <= dp_d;
        end
    end

    assign seg      = seg_q;
    assign an       = an_q;
    assign dp       = dp_q;
    assign best_out = best_q;
    assign busy     = conv_busy;

endmodule

// File: tb/tb_score_display.sv
// Bench for score_display: vector table, latency/corner sequences and random scores
// compared against a decimal-arithmetic reference model.
module tb_score_display;

    localparam int RD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] score = 7'd0;
    logic       show_best = 1'b0;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic [6:0] best_out;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int model_best = 0;

    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    typedef struct {
        int         score;
        bit         sb;
        int         exp_best;
        logic [6:0] e0;
        logic [6:0] e1;
        logic [6:0] e2;
    } vec_t;

    vec_t vecs [9];

    score_display #(.REFRESH_DIV(RD), .SCORE_W(7)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .score     (score),
        .show_best (show_best),
        .seg       (seg),
        .dp        (dp),
        .an        (an),
        .best_out  (best_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply(input int s, input bit sb);
        @(posedge clk);
        #1;
        score     = 7'(s);
        show_best = sb;
        if (s > model_best) model_best = s;
    endtask

    function automatic logic [6:0] model_code(input int v, input int d);
        int h, t, o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
        if (d == 0) return seg_tab[o];
        if (d == 1) return (h == 0 && t == 0) ? 7'h7F : seg_tab[t];
        return (h == 0) ? 7'h7F : seg_tab[h];
    endfunction

    // One full scan period; blank slots leave 7F in their digit.
    task automatic observe(output logic [6:0] d0, output logic [6:0] d1,
                           output logic [6:0] d2, output int bad);
        d0 = 7'h7F; d1 = 7'h7F; d2 = 7'h7F; bad = 0;
        repeat (4*RD) begin
            @(negedge clk);
            case (an)
                4'b1110: begin d0 = seg; if (dp !== ~show_best) bad++; end
                4'b1101: begin d1 = seg; if (dp !== 1'b1) bad++; end
                4'b1011: begin d2 = seg; if (dp !== 1'b1) bad++; end
                4'b1111: if (seg !== 7'h7F || dp !== 1'b1) bad++;
                default: bad++;
            endcase
        end
    endtask

    task automatic check_digits(input string tag, input logic [6:0] e0,
                                input logic [6:0] e1, input logic [6:0] e2);
        logic [6:0] d0, d1, d2;
        int bad;
        observe(d0, d1, d2, bad);
        check({tag, " ones"}, d0, e0);
        check({tag, " tens"}, d1, e1);
        check({tag, " hund"}, d2, e2);
        check({tag, " scan"}, bad, 0);
    endtask

    task automatic check_model(input string tag);
        int v;
        v = show_best ? model_best : int'(score);
        check({tag, " best"}, best_out, model_best);
        check_digits(tag, model_code(v, 0), model_code(v, 1), model_code(v, 2));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " seg"},  seg, 7'h7F);
        check({tag, " an"},   an, 4'hF);
        check({tag, " dp"},   dp, 1'b1);
        check({tag, " best"}, best_out, 0);
        check({tag, " busy"}, busy, 1'b0);
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        score = 7'd0;
        show_best = 1'b0;
        rst_n = 1'b0;
        #3;
        rst_n = 1'b1;
        model_best = 0;
    endtask

    initial begin
        int busy_rises, bad_codes;
        bit seen99;
        logic prev_busy;

        vecs[0] = '{0,   1'b0, 0,   7'h40, 7'h7F, 7'h7F};
        vecs[1] = '{5,   1'b0, 5,   7'h12, 7'h7F, 7'h7F};
        vecs[2] = '{42,  1'b0, 42,  7'h24, 7'h19, 7'h7F};
        vecs[3] = '{17,  1'b1, 42,  7'h24, 7'h19, 7'h7F};
        vecs[4] = '{17,  1'b0, 42,  7'h78, 7'h79, 7'h7F};
        vecs[5] = '{127, 1'b0, 127, 7'h78, 7'h24, 7'h79};
        vecs[6] = '{100, 1'b1, 127, 7'h78, 7'h24, 7'h79};
        vecs[7] = '{100, 1'b0, 127, 7'h40, 7'h40, 7'h79};
        vecs[8] = '{10,  1'b0, 127, 7'h40, 7'h79, 7'h7F};

        #12;
        check_reset_outputs("in reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick(3);
        check_digits("after reset", 7'h40, 7'h7F, 7'h7F);

        // 0 -> 127: busy from E2 through E9
        apply(127, 1'b0);
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            check($sformatf("busy E%0d", e), busy, (e >= 2 && e <= 9));
        end
        check_digits("127", 7'h78, 7'h24, 7'h79);

        reset_pulse();
        tick(3);
        for (int i = 0; i < 9; i++) begin
            apply(vecs[i].score, vecs[i].sb);
            tick(30);
            check($sformatf("vec%0d best", i), best_out, vecs[i].exp_best);
            check_digits($sformatf("vec%0d", i), vecs[i].e0, vecs[i].e1, vecs[i].e2);
        end

        // 99 then 100 while the first conversion is running
        apply(99, 1'b0);
        busy_rises = 0; bad_codes = 0; seen99 = 0; prev_busy = 1'b0;
        for (int c = 0; c < 45; c++) begin
            @(negedge clk);
            if (c == 2) begin
                score = 7'd100;
                model_best = (model_best > 100) ? model_best : 100;
            end
            if (busy === 1'b1 && prev_busy === 1'b0) busy_rises++;
            prev_busy = busy;
            case (an)
                4'b1110: if (seg !== 7'h40 && seg !== 7'h10) bad_codes++;
                4'b1101: if (seg !== 7'h79 && seg !== 7'h10 && seg !== 7'h40) bad_codes++;
                4'b1011: if (seg !== 7'h79) bad_codes++;
                4'b1111: if (seg !== 7'h7F) bad_codes++;
                default: bad_codes++;
            endcase
            if ((an == 4'b1110 || an == 4'b1101) && seg == 7'h10) seen99 = 1'b1;
        end
        check("mid busy rises", busy_rises, 2);
        check("mid bad codes", bad_codes, 0);
        check("mid saw 99", seen99, 1'b1);
        check_digits("mid final", 7'h40, 7'h40, 7'h79);

        // async reset in the middle of a conversion
        reset_pulse();
        apply(42, 1'b0);
        tick(30);
        check("pre-reset best", best_out, 42);
        apply(7, 1'b0);
        tick(3);
        check("in convert busy", busy, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async reset");
        #3;
        rst_n = 1'b1;
        model_best = 7;
        tick(30);
        check_model("post reset");

        for (int r = 0; r < 20; r++) begin
            apply(int'($urandom_range(0, 127)), 1'($urandom_range(0, 1)));
            tick(30);
            check_model($sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
